// File: rtl/id_ctrl_pkg.sv
// rtl/id_ctrl_pkg.sv - shared opcodes, ALU/writeback encodings and control bundle for the ID stage
package id_ctrl_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'b0000,
    ALU_SUB    = 4'b0001,
    ALU_SLT    = 4'b0010,
    ALU_SLTU   = 4'b0011,
    ALU_XOR    = 4'b0100,
    ALU_OR     = 4'b0101,
    ALU_AND    = 4'b0110,
    ALU_SLL    = 4'b0111,
    ALU_SRL    = 4'b1000,
    ALU_SRA    = 4'b1001,
    ALU_PASS_B = 4'b1010
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10
  } wb_sel_e;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  typedef struct packed {
    logic [4:0] rs1_addr;
    logic [4:0] rs2_addr;
    logic [4:0] rd_addr;
    alu_op_e    alu_op;
    logic       opa_sel;
    logic       opb_sel;
    logic       rd_wren;
    logic       mem_wren;
    logic       mem_rden;
    logic [2:0] mem_size;
    wb_sel_e    wb_sel;
    logic       branch;
    logic       jump;
    logic [2:0] br_type;
    logic       insn_vld;
  } ctrl_t;

  // funct3 -> ALU op for OP / OP-IMM; alt carries the funct7[5] modifier already qualified by the caller
  function automatic alu_op_e alu_from_funct3(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic logic br_funct3_ok(input logic [2:0] f3);
    return (f3 == BR_BEQ) || (f3 == BR_BNE) || (f3 == BR_BLT) ||
           (f3 == BR_BGE) || (f3 == BR_BLTU) || (f3 == BR_BGEU);
  endfunction

endpackage

// File: rtl/id_decode.sv
// rtl/id_decode.sv - combinational RV32I decoder producing the control bundle and immediate
module id_decode
  import id_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     i_instr,
  output ctrl_t           o_ctrl,
  output logic [XLEN-1:0] o_imm,
  output logic            o_uses_rs1,
  output logic            o_uses_rs2
);

  logic [6:0]         w_opcode;
  logic [2:0]         w_funct3;
  logic               w_alt;
  logic signed [31:0] w_imm_i;
  logic signed [31:0] w_imm_s;
  logic signed [31:0] w_imm_b;
  logic signed [31:0] w_imm_u;
  logic signed [31:0] w_imm_j;
  logic signed [31:0] w_imm;
  logic               w_shift_imm;
  logic               w_legal;
  logic               w_rd_wr;

  assign w_opcode    = i_instr[6:0];
  assign w_funct3    = i_instr[14:12];
  assign w_alt       = i_instr[30];
  assign w_imm_i     = {{20{i_instr[31]}}, i_instr[31:20]};
  assign w_imm_s     = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign w_imm_b     = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
  assign w_imm_u     = {i_instr[31:12], 12'b0};
  assign w_imm_j     = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
  // shift-immediates carry funct7 in the upper I-field, so only the shamt is the operand
  assign w_shift_imm = (w_funct3 == 3'b001) || (w_funct3 == 3'b101);
  assign o_imm       = XLEN'(w_imm);

  // opcode decode; illegal encodings keep only the raw register fields and kill every enable
  always_comb begin
    o_ctrl          = '0;
    o_ctrl.rs1_addr = i_instr[19:15];
    o_ctrl.rs2_addr = i_instr[24:20];
    o_ctrl.rd_addr  = i_instr[11:7];
    w_imm           = '0;
    o_uses_rs1      = 1'b0;
    o_uses_rs2      = 1'b0;
    w_legal         = 1'b1;
    w_rd_wr         = 1'b0;
    case (w_opcode)
      OPC_LUI: begin
        o_ctrl.alu_op  = ALU_PASS_B;
        o_ctrl.opb_sel = 1'b1;
        w_rd_wr        = 1'b1;
        w_imm          = w_imm_u;
      end
      OPC_AUIPC: begin
        o_ctrl.opa_sel = 1'b1;
        o_ctrl.opb_sel = 1'b1;
        w_rd_wr        = 1'b1;
        w_imm          = w_imm_u;
      end
      OPC_JAL: begin
        o_ctrl.opa_sel = 1'b1;
        o_ctrl.opb_sel = 1'b1;
        o_ctrl.wb_sel  = WB_PC4;
        o_ctrl.jump    = 1'b1;
        w_rd_wr        = 1'b1;
        w_imm          = w_imm_j;
      end
      OPC_JALR: begin
        w_legal        = (w_funct3 == 3'b000);
        o_uses_rs1     = 1'b1;
        o_ctrl.opb_sel = 1'b1;
        o_ctrl.wb_sel  = WB_PC4;
        o_ctrl.jump    = 1'b1;
        w_rd_wr        = 1'b1;
        w_imm          = w_imm_i;
      end
      OPC_BRANCH: begin
        w_legal        = br_funct3_ok(w_funct3);
        o_uses_rs1     = 1'b1;
        o_uses_rs2     = 1'b1;
        o_ctrl.opa_sel = 1'b1;
        o_ctrl.opb_sel = 1'b1;
        o_ctrl.branch  = 1'b1;
        o_ctrl.br_type = w_funct3;
        w_imm          = w_imm_b;
      end
      OPC_LOAD: begin
        w_legal         = (w_funct3 != 3'b011) && (w_funct3 != 3'b110) && (w_funct3 != 3'b111);
        o_uses_rs1      = 1'b1;
        o_ctrl.opb_sel  = 1'b1;
        o_ctrl.mem_rden = 1'b1;
        o_ctrl.mem_size = w_funct3;
        o_ctrl.wb_sel   = WB_LOAD;
        w_rd_wr         = 1'b1;
        w_imm           = w_imm_i;
      end
      OPC_STORE: begin
        w_legal         = (w_funct3 <= 3'b010);
        o_uses_rs1      = 1'b1;
        o_uses_rs2      = 1'b1;
        o_ctrl.opb_sel  = 1'b1;
        o_ctrl.mem_wren = 1'b1;
        o_ctrl.mem_size = w_funct3;
        w_imm           = w_imm_s;
      end
      OPC_OPIMM: begin
        o_uses_rs1     = 1'b1;
        o_ctrl.opb_sel = 1'b1;
        o_ctrl.alu_op  = alu_from_funct3(w_funct3, w_alt && (w_funct3 == 3'b101));
        w_rd_wr        = 1'b1;
        w_imm          = w_shift_imm ? {27'b0, i_instr[24:20]} : w_imm_i;
      end
      OPC_OP: begin
        o_uses_rs1    = 1'b1;
        o_uses_rs2    = 1'b1;
        o_ctrl.alu_op = alu_from_funct3(w_funct3, w_alt);
        w_rd_wr       = 1'b1;
      end
      default: w_legal = 1'b0;
    endcase
    if (!w_legal) begin
      o_ctrl          = '0;
      o_ctrl.rs1_addr = i_instr[19:15];
      o_ctrl.rs2_addr = i_instr[24:20];
      o_ctrl.rd_addr  = i_instr[11:7];
      w_imm           = '0;
      o_uses_rs1      = 1'b0;
      o_uses_rs2      = 1'b0;
    end
    o_ctrl.insn_vld = w_legal;
    o_ctrl.rd_wren  = w_legal && w_rd_wr && (i_instr[11:7] != 5'd0);
  end

endmodule

// File: rtl/id_ctrl_stage.sv
// rtl/id_ctrl_stage.sv - decode/issue stage with ID/EX register, handshake, load-use interlock and flush
module id_ctrl_stage
  import id_ctrl_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_valid,
  input  logic [31:0]      if_instr,
  input  logic [XLEN-1:0]  if_pc,
  output logic             id_ready,
  input  logic             flush,
  input  logic             ex_ready,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1_addr,
  output logic [4:0]       ex_rs2_addr,
  output logic [4:0]       ex_rd_addr,
  output logic [3:0]       ex_alu_op,
  output logic             ex_opa_sel,
  output logic             ex_opb_sel,
  output logic             ex_rd_wren,
  output logic             ex_mem_wren,
  output logic             ex_mem_rden,
  output logic [2:0]       ex_mem_size,
  output logic [1:0]       ex_wb_sel,
  output logic             ex_branch,
  output logic             ex_jump,
  output logic [2:0]       ex_br_type,
  output logic             ex_insn_vld,
  output logic [CNT_W-1:0] perf_bubbles
);

  ctrl_t             w_ctrl;
  logic [XLEN-1:0]   w_imm;
  logic              w_uses_rs1;
  logic              w_uses_rs2;
  logic              w_hazard;

  ctrl_t             r_ctrl;
  logic [XLEN-1:0]   r_imm;
  logic [XLEN-1:0]   r_pc;
  logic              r_valid;
  logic [CNT_W-1:0]  r_bubbles;

  id_decode #(.XLEN(XLEN)) u_decode (
    .i_instr    (if_instr),
    .o_ctrl     (w_ctrl),
    .o_imm      (w_imm),
    .o_uses_rs1 (w_uses_rs1),
    .o_uses_rs2 (w_uses_rs2)
  );

  // a load sitting in the ID/EX register cannot forward to the instruction right behind it
  always_comb begin
    w_hazard = r_valid && r_ctrl.mem_rden && (r_ctrl.rd_addr != 5'd0) && if_valid &&
               ((w_uses_rs1 && (w_ctrl.rs1_addr == r_ctrl.rd_addr)) ||
                (w_uses_rs2 && (w_ctrl.rs2_addr == r_ctrl.rd_addr)));
  end

  // flush consumes and drops the incoming instruction, so ready is asserted regardless of stall
  assign id_ready = rst_n && (flush || ((!r_valid || ex_ready) && !w_hazard));

  // ID/EX register: reset > flush > hold > bubble > load
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_ctrl    <= '0;
      r_imm     <= '0;
      r_pc      <= '0;
      r_bubbles <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (r_valid && !ex_ready) begin
      r_valid <= r_valid;
    end else if (w_hazard) begin
      r_valid <= 1'b0;
      if (r_bubbles != '1) r_bubbles <= r_bubbles + CNT_W'(1);
    end else begin
      r_valid <= if_valid;
      r_ctrl  <= w_ctrl;
      r_imm   <= w_imm;
      r_pc    <= if_pc;
    end
  end

  assign ex_valid     = r_valid;
  assign ex_pc        = r_pc;
  assign ex_imm       = r_imm;
  assign ex_rs1_addr  = r_ctrl.rs1_addr;
  assign ex_rs2_addr  = r_ctrl.rs2_addr;
  assign ex_rd_addr   = r_ctrl.rd_addr;
  assign ex_alu_op    = r_ctrl.alu_op;
  assign ex_opa_sel   = r_ctrl.opa_sel;
  assign ex_opb_sel   = r_ctrl.opb_sel;
  assign ex_rd_wren   = r_ctrl.rd_wren;
  assign ex_mem_wren  = r_ctrl.mem_wren;
  assign ex_mem_rden  = r_ctrl.mem_rden;
  assign ex_mem_size  = r_ctrl.mem_size;
  assign ex_wb_sel    = r_ctrl.wb_sel;
  assign ex_branch    = r_ctrl.branch;
  assign ex_jump      = r_ctrl.jump;
  assign ex_br_type   = r_ctrl.br_type;
  assign ex_insn_vld  = r_ctrl.insn_vld;
  assign perf_bubbles = r_bubbles;

endmodule

// File: tb/tb_id_ctrl_stage.sv
// tb/tb_id_ctrl_stage.sv - scoreboard bench for id_ctrl_stage with a spec-level decode model
module tb_id_ctrl_stage;

  localparam int CW  = 2;
  localparam int MAX = (1 << CW) - 1;

  logic        clk = 1'b0;
  logic        rst_n, if_valid, flush, ex_ready;
  logic [31:0] if_instr, if_pc;
  logic        id_ready, ex_valid;
  logic [31:0] ex_pc, ex_imm;
  logic [4:0]  ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
  logic [3:0]  ex_alu_op;
  logic        ex_opa_sel, ex_opb_sel, ex_rd_wren, ex_mem_wren, ex_mem_rden;
  logic [2:0]  ex_mem_size, ex_br_type;
  logic [1:0]  ex_wb_sel;
  logic        ex_branch, ex_jump, ex_insn_vld;
  logic [CW-1:0] perf_bubbles;

  id_ctrl_stage #(.XLEN(32), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_ready(id_ready), .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr),
    .ex_rd_addr(ex_rd_addr), .ex_alu_op(ex_alu_op), .ex_opa_sel(ex_opa_sel),
    .ex_opb_sel(ex_opb_sel), .ex_rd_wren(ex_rd_wren), .ex_mem_wren(ex_mem_wren),
    .ex_mem_rden(ex_mem_rden), .ex_mem_size(ex_mem_size), .ex_wb_sel(ex_wb_sel),
    .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_br_type(ex_br_type),
    .ex_insn_vld(ex_insn_vld), .perf_bubbles(perf_bubbles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        legal, rdw, mw, mr, br, jp, opa, opb, u1, u2, has_imm;
    logic [3:0]  alu;
    logic [1:0]  wb;
    logic [2:0]  size, brt;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm, pc;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  logic       m_valid = 1'b0;
  logic       m_load = 1'b0;
  logic [4:0] m_rd = '0;
  int         m_bub = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
  endtask

  function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
    logic [31:0] m;
    m = 32'(1) << (bits - 1);
    return (v ^ m) - m;
  endfunction

  // reference decode written from the ISA rules
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
    exp_t       e;
    logic [3:0] alu_tab [8];
    logic [6:0] op;
    logic [2:0] f3;
    logic       writes;
    alu_tab = '{4'h0, 4'h7, 4'h2, 4'h3, 4'h4, 4'h8, 4'h5, 4'h6};
    op = ins[6:0];
    f3 = ins[14:12];
    e = '{default: '0};
    e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7]; e.pc = pc;
    e.has_imm = 1'b1; e.legal = 1'b1; writes = 1'b0;
    case (op)
      7'b0110111: begin e.alu = 4'hA; e.opb = 1; writes = 1; e.imm = {ins[31:12], 12'h000}; end
      7'b0010111: begin e.opa = 1; e.opb = 1; writes = 1; e.imm = {ins[31:12], 12'h000}; end
      7'b1101111: begin
        e.opa = 1; e.opb = 1; e.wb = 2; e.jp = 1; writes = 1;
        e.imm = sext({11'b0, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}, 21);
      end
      7'b1100111: begin
        e.legal = (f3 == 0); e.opb = 1; e.wb = 2; e.jp = 1; writes = 1;
        e.imm = sext({20'b0, ins[31:20]}, 12);
      end
      7'b1100011: begin
        e.legal = !(f3 == 2 || f3 == 3); e.opa = 1; e.opb = 1; e.br = 1; e.brt = f3;
        e.imm = sext({19'b0, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}, 13);
      end
      7'b0000011: begin
        e.legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        e.opb = 1; e.mr = 1; e.size = f3; e.wb = 1; writes = 1;
        e.imm = sext({20'b0, ins[31:20]}, 12);
      end
      7'b0100011: begin
        e.legal = (f3 <= 2); e.opb = 1; e.mw = 1; e.size = f3;
        e.imm = sext({20'b0, ins[31:25], ins[11:7]}, 12);
      end
      7'b0010011: begin
        e.alu = alu_tab[f3];
        if (ins[30] && f3 == 5) e.alu = 4'h9;
        e.opb = 1; writes = 1;
        e.imm = (f3 == 1 || f3 == 5) ? {27'd0, ins[24:20]} : sext({20'b0, ins[31:20]}, 12);
      end
      7'b0110011: begin
        e.alu = alu_tab[f3];
        if (ins[30] && f3 == 0) e.alu = 4'h1;
        if (ins[30] && f3 == 5) e.alu = 4'h9;
        writes = 1; e.has_imm = 0;
      end
      default: e.legal = 1'b0;
    endcase
    e.u1  = e.legal && !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
    e.u2  = e.legal && (op == 7'b1100011 || op == 7'b0100011 || op == 7'b0110011);
    e.rdw = e.legal && writes && (e.rd != 0);
    if (!e.legal) begin
      e.mw = 0; e.mr = 0; e.br = 0; e.jp = 0;
    end
    return e;
  endfunction

  // one clock of stimulus; the model decides what the ID/EX slot holds after the edge
  task automatic step(input logic rst, input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic fl, input logic rdy, output logic acc);
    exp_t d;
    logic haz, rdy_exp;
    rst_n = rst; if_valid = v; if_instr = ins; if_pc = pc; flush = fl; ex_ready = rdy;
    d = ref_decode(ins, pc);
    haz = m_valid && m_load && (m_rd != 0) && v &&
          ((d.u1 && d.rs1 == m_rd) || (d.u2 && d.rs2 == m_rd));
    rdy_exp = rst && (fl || ((!m_valid || rdy) && !haz));
    #1;
    chk("id_ready", 64'(id_ready), 64'(rdy_exp));
    @(posedge clk);
    acc = 1'b0;
    if (!rst) begin
      m_valid = 0; m_bub = 0;
    end else if (fl) begin
      m_valid = 0; acc = v;
    end else if (m_valid && !rdy) begin
      acc = 1'b0;
    end else if (haz) begin
      m_valid = 0;
      if (m_bub < MAX) m_bub++;
    end else begin
      m_valid = v;
      if (v) begin
        m_load = d.mr; m_rd = d.rd; exp_q.push_back(d); acc = 1'b1;
      end
    end
    #2;
    chk("perf_bubbles", 64'(perf_bubbles), 64'(m_bub));
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
    logic acc;
    int   n;
    n = 0;
    do begin
      step(1'b1, 1'b1, ins, pc, 1'b0, 1'b1, acc);
      n++;
    end while (!acc && n < 8);
    if (!acc) chk("issue_timeout", 64'(0), 64'(1));
  endtask

  // monitor: whatever ex_* shows must be the oldest expected bundle
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (ex_valid !== (exp_q.size() != 0)) begin
        chk("ex_valid", 64'(ex_valid), 64'(exp_q.size() != 0));
      end else if (ex_valid) begin
        if (exp_q[0].legal) begin
          chk("ctrl", 64'({ex_alu_op, ex_opa_sel, ex_opb_sel, ex_rd_wren, ex_mem_wren, ex_mem_rden,
                          ex_mem_size, ex_wb_sel, ex_branch, ex_jump, ex_br_type, ex_insn_vld,
                          ex_rs1_addr, ex_rs2_addr, ex_rd_addr}),
              64'({exp_q[0].alu, exp_q[0].opa, exp_q[0].opb, exp_q[0].rdw, exp_q[0].mw, exp_q[0].mr,
                   exp_q[0].size, exp_q[0].wb, exp_q[0].br, exp_q[0].jp, exp_q[0].brt, 1'b1,
                   exp_q[0].rs1, exp_q[0].rs2, exp_q[0].rd}));
          if (exp_q[0].has_imm) chk("imm", 64'(ex_imm), 64'(exp_q[0].imm));
        end else begin
          chk("illegal_ctrl", 64'({ex_insn_vld, ex_rd_wren, ex_mem_wren, ex_mem_rden, ex_branch, ex_jump}),
              64'({1'b0, exp_q[0].rdw, exp_q[0].mw, exp_q[0].mr, exp_q[0].br, exp_q[0].jp}));
        end
        chk("pc", 64'(ex_pc), 64'(exp_q[0].pc));
      end
      if (exp_q.size() != 0 && (flush || ex_ready)) void'(exp_q.pop_front());
    end
  end

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [10];
    logic [31:0] r;
    ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
            7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b1111111};
    r = $urandom;
    r[6:0]   = ops[$urandom_range(0, 9)];
    r[11:7]  = 5'($urandom_range(0, 3));
    r[19:15] = 5'($urandom_range(0, 3));
    r[24:20] = 5'($urandom_range(0, 3));
    return r;
  endfunction

  localparam logic [31:0] I_ADDI  = 32'h00500093;
  localparam logic [31:0] I_OR    = 32'h0020E1B3;
  localparam logic [31:0] I_SRAI  = 32'h4030D213;
  localparam logic [31:0] I_LW5   = 32'h0000A283;
  localparam logic [31:0] I_ADD65 = 32'h00228333;
  localparam logic [31:0] I_LW0   = 32'h0000A003;
  localparam logic [31:0] I_ADD60 = 32'h00200333;
  localparam logic [31:0] I_BEQ   = 32'hFE000CE3;

  initial begin
    logic        acc, have, cur_v;
    logic [31:0] cur, cur_pc, pc;

    step(1'b0, 1'b1, I_ADDI, 32'h0, 1'b0, 1'b1, acc);
    step(1'b0, 1'b1, I_ADDI, 32'h0, 1'b0, 1'b1, acc);
    chk("rst_ex_valid", 64'(ex_valid), 64'(0));
    chk("rst_data", 64'({ex_pc, ex_imm}), 64'(0));
    chk("rst_ctrl", 64'({ex_alu_op, ex_opa_sel, ex_opb_sel, ex_rd_wren, ex_mem_wren, ex_mem_rden,
                         ex_mem_size, ex_wb_sel, ex_branch, ex_jump, ex_br_type, ex_insn_vld,
                         ex_rs1_addr, ex_rs2_addr, ex_rd_addr}), 64'(0));

    issue(I_ADDI, 32'h100);
    chk("addi", 64'({ex_valid, ex_alu_op, ex_opb_sel, ex_rd_wren, ex_imm}), {31'd0, 1'b1, 4'h0, 1'b1, 1'b1, 32'd5});
    issue(I_OR, 32'h104);
    chk("or_alu", 64'(ex_alu_op), 64'(5));
    issue(I_SRAI, 32'h108);
    chk("srai", 64'({ex_alu_op, ex_imm}), 64'({4'h9, 32'd3}));

    issue(I_LW5, 32'h10C);
    issue(I_ADD65, 32'h110);
    chk("loaduse_bubbles", 64'(perf_bubbles), 64'(1));
    issue(I_LW0, 32'h114);
    issue(I_ADD60, 32'h118);
    chk("x0_no_bubble", 64'(perf_bubbles), 64'(1));

    issue(I_BEQ, 32'h200);
    chk("beq_imm", 64'(ex_imm), 64'(32'hFFFFFFF8));
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b1, I_ADDI, 32'h204, 1'b0, 1'b0, acc);
      chk("stall_pc", 64'({ex_valid, ex_pc}), 64'({1'b1, 32'h200}));
    end
    issue(I_ADDI, 32'h204);

    step(1'b1, 1'b1, I_OR, 32'h300, 1'b1, 1'b0, acc);
    chk("flush_valid", 64'(ex_valid), 64'(0));
    issue(32'hFFFFFFFF, 32'h304);
    chk("illegal", 64'({ex_valid, ex_insn_vld, ex_rd_wren, ex_mem_wren, ex_mem_rden, ex_branch, ex_jump}),
        64'(7'b1000000));
    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc);

    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc);
    for (int k = 0; k < 4; k++) begin
      issue(I_LW5, 32'h400 + 32'(k * 8));
      issue(I_ADD65, 32'h404 + 32'(k * 8));
      chk("sat_count", 64'(perf_bubbles), 64'((k + 1 > MAX) ? MAX : k + 1));
    end
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc);
    chk("rst_clears_count", 64'(perf_bubbles), 64'(0));

    issue(I_LW5, 32'h500);
    issue(I_LW5, 32'h504);
    step(1'b0, 1'b1, I_ADD65, 32'h508, 1'b0, 1'b1, acc);
    chk("rst_midstall", 64'({ex_valid, perf_bubbles}), 64'(0));
    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc);
    chk("rst_midstall_noissue", 64'(ex_valid), 64'(0));

    have = 1'b0; cur_v = 1'b0; cur = '0; cur_pc = '0; pc = 32'h1000;
    for (int c = 0; c < 800; c++) begin
      logic rs, fl, rdy;
      if (!have) begin
        cur = rand_instr(); cur_pc = pc; pc = pc + 4;
        cur_v = ($urandom_range(0, 9) != 0);
      end
      rs  = ($urandom_range(0, 99) != 0);
      fl  = ($urandom_range(0, 15) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      step(rs, cur_v, cur, cur_pc, fl, rdy, acc);
      have = cur_v && !acc && rs;
    end
    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc);
    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
